// File: rtl/lane_pipe_reg.sv
// Multi-lane pipeline register with valid/ready flow control, per-lane masking,
// flush and occupancy count. Empty stages always refill, so bubbles collapse.

module lane_pipe_lane #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [DEPTH-1:0] adv,
    input  logic             cap,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [DEPTH-1:0][WIDTH-1:0] d;

    // Masked or invalid captures load zero, so later stages can copy blindly.
    always_ff @(posedge clk) begin
        if (clr) begin
            d <= '0;
        end else begin
            if (adv[0]) d[0] <= cap ? din : '0;
            for (int k = 1; k < DEPTH; k++)
                if (adv[k]) d[k] <= d[k-1];
        end
    end

    assign dout = d[DEPTH-1];
endmodule

module lane_pipe_reg #(
    parameter  int LANES = 2,
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH+1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES-1:0]       in_lane_en,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES-1:0]       out_lane_en,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [CW-1:0]          count
);
    localparam int STAGES = DEPTH-1;

    logic [STAGES:0]            vld_pipe;
    logic [STAGES:0][LANES-1:0] msk_pipe;
    logic [DEPTH-1:0]           adv;
    logic                       acc;
    logic                       emit;
    logic                       clr;

    // adv[k] is set when out_ready or any stage at or downstream of k is empty.
    always_comb begin
        logic a;
        a   = out_ready;
        adv = '0;
        for (int k = STAGES; k >= 0; k--) begin
            a      = a | ~vld_pipe[k];
            adv[k] = a;
        end
    end

    assign in_ready = adv[0] & ~flush;
    assign acc      = in_valid & in_ready;
    assign emit     = vld_pipe[STAGES] & out_ready;
    assign clr      = ~reset | flush;

    always_ff @(posedge clk) begin
        if (clr) begin
            vld_pipe <= '0;
            msk_pipe <= '0;
            count    <= '0;
        end else begin
            if (adv[0]) begin
                vld_pipe[0] <= acc;
                msk_pipe[0] <= acc ? in_lane_en : '0;
            end
            for (int k = 1; k <= STAGES; k++) begin
                if (adv[k]) begin
                    vld_pipe[k] <= vld_pipe[k-1];
                    msk_pipe[k] <= msk_pipe[k-1];
                end
            end
            count <= count + CW'(acc) - CW'(emit);
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lane_pipe_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane (
            .clk  (clk),
            .clr  (clr),
            .adv  (adv),
            .cap  (acc & in_lane_en[i]),
            .din  (in_data[i*WIDTH +: WIDTH]),
            .dout (out_data[i*WIDTH +: WIDTH])
        );
    end

    assign out_valid   = vld_pipe[STAGES];
    assign out_lane_en = msk_pipe[STAGES];
endmodule

// File: tb/tb_lane_pipe_reg.sv
// Bench for lane_pipe_reg: directed vector table plus random traffic checked
// against a timestamped FIFO model of the pipe.

module tb_lane_pipe_reg;
    localparam int LANES = 2;
    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH+1);
    localparam int DW    = LANES*WIDTH;

    logic             clk;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [LANES-1:0] in_lane_en;
    logic [DW-1:0]    in_data;
    logic             out_valid;
    logic             out_ready;
    logic [LANES-1:0] out_lane_en;
    logic [DW-1:0]    out_data;
    logic [CW-1:0]    count;

    lane_pipe_reg #(.LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_lane_en  (in_lane_en),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_lane_en (out_lane_en),
        .out_data    (out_data),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [LANES-1:0] en;
        logic [DW-1:0]    data;
        int               t;
    } grp_t;

    typedef struct {
        logic        iv;
        logic [1:0]  en;
        logic [15:0] d;
        logic        ordy;
        logic        fl;
        logic        rdy;
        logic        ov;
        logic [1:0]  oen;
        logic [15:0] od;
        int          cnt;
    } vec_t;

    grp_t q[$];
    vec_t tbl[19];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic rdy_seen;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %h want %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mask_data(input logic [LANES-1:0] en, input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++)
            if (en[i]) r[i*WIDTH +: WIDTH] = d[i*WIDTH +: WIDTH];
        return r;
    endfunction

    // The oldest group reaches the output DEPTH-1 edges after its acceptance.
    function automatic logic m_vis();
        return q.size() > 0 && ((cyc - 1) - q[0].t) >= DEPTH-1;
    endfunction

    task automatic check_outputs();
        logic vis;
        vis = m_vis();
        chk("out_valid", out_valid, vis);
        chk("out_lane_en", out_lane_en, vis ? q[0].en : '0);
        chk("out_data", out_data, vis ? q[0].data : '0);
        chk("count", count, q.size());
    endtask

    task automatic step(input logic rst, input logic fl, input logic iv,
                        input logic [LANES-1:0] en, input logic [DW-1:0] d, input logic ordy);
        logic mrdy;
        logic vis;
        reset = rst; flush = fl; in_valid = iv; in_lane_en = en; in_data = d; out_ready = ordy;
        #1;
        mrdy = !fl && (q.size() < DEPTH || ordy);
        chk("in_ready", in_ready, mrdy);
        rdy_seen = in_ready;
        vis = m_vis();
        @(posedge clk);
        if (!rst || fl) begin
            q.delete();
        end else begin
            if (vis && ordy) void'(q.pop_front());
            if (iv && mrdy) q.push_back('{en, mask_data(en, d), cyc});
        end
        cyc++;
        #1;
        check_outputs();
    endtask

    initial begin
        tbl[0]  = '{1'b1, 2'b11, 16'h0102, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 16'h0000, 1};
        tbl[1]  = '{1'b1, 2'b11, 16'h0304, 1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 16'h0102, 2};
        tbl[2]  = '{1'b1, 2'b11, 16'h0506, 1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 16'h0304, 2};
        tbl[3]  = '{1'b1, 2'b01, 16'hA5C3, 1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 16'h0506, 2};
        tbl[4]  = '{1'b0, 2'b11, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 16'h00C3, 1};
        tbl[5]  = '{1'b0, 2'b00, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 16'h0000, 0};
        tbl[6]  = '{1'b1, 2'b11, 16'h1111, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 16'h0000, 1};
        tbl[7]  = '{1'b1, 2'b11, 16'h2222, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 16'h1111, 2};
        tbl[8]  = '{1'b1, 2'b11, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 16'h1111, 2};
        tbl[9]  = '{1'b1, 2'b11, 16'h3333, 1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 16'h2222, 2};
        tbl[10] = '{1'b0, 2'b11, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 16'h3333, 1};
        tbl[11] = '{1'b0, 2'b11, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 16'h0000, 0};
        tbl[12] = '{1'b1, 2'b11, 16'h4444, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 16'h0000, 1};
        tbl[13] = '{1'b1, 2'b11, 16'h5555, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 16'h4444, 2};
        tbl[14] = '{1'b1, 2'b11, 16'h6666, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 16'h0000, 0};
        tbl[15] = '{1'b0, 2'b11, 16'h6666, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 16'h0000, 0};
        tbl[16] = '{1'b1, 2'b00, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 16'h0000, 1};
        tbl[17] = '{1'b0, 2'b11, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 16'h0000, 1};
        tbl[18] = '{1'b0, 2'b11, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 16'h0000, 0};

        // Reset held two edges while a full-ones group is offered.
        reset = 1'b0; flush = 1'b0; in_valid = 1'b1; in_lane_en = '1; in_data = 16'hFFFF; out_ready = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
        step(1'b0, 1'b0, 1'b1, 2'b11, 16'hFFFF, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 16'h0000);
        chk("rst_count", count, 0);
        reset = 1'b1; in_valid = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);

        for (int r = 0; r < 19; r++) begin
            step(1'b1, tbl[r].fl, tbl[r].iv, tbl[r].en, tbl[r].d, tbl[r].ordy);
            chk($sformatf("tbl%0d_in_ready", r), rdy_seen, tbl[r].rdy);
            chk($sformatf("tbl%0d_out_valid", r), out_valid, tbl[r].ov);
            chk($sformatf("tbl%0d_out_lane_en", r), out_lane_en, tbl[r].oen);
            chk($sformatf("tbl%0d_out_data", r), out_data, tbl[r].od);
            chk($sformatf("tbl%0d_count", r), count, tbl[r].cnt);
        end

        for (int n = 0; n < 10000; n++) begin
            step(($urandom % 509) != 0, ($urandom % 97) == 0, ($urandom % 4) != 0,
                 LANES'($urandom), DW'($urandom), ($urandom % 3) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lane_pipe_reg.md
# lane_pipe_reg

Parametrised multi-lane pipeline register with valid/ready flow control, per-lane enable masking, flush and occupancy reporting. It generalises the fixed 2-lane × 8-bit register stage used between PCIe physical-layer sub-blocks (byte striping, scrambling, serialisation) to N lanes, arbitrary lane width and arbitrary depth. It also adds back-pressure, so a stalled downstream block holds data instead of losing it. It sits on any lane-parallel datapath in the transmit or receive path.

## Interface
- LANES, 2, number of parallel lanes (≥1)
- WIDTH, 8, bits per lane (≥1)
- DEPTH, 2, number of register stages (≥1)
- CW, $clog2(DEPTH+1), width of the occupancy count (derived, not overridden)

- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  synchronous, active-low; clock clk
- flush  in  1  synchronous pipeline clear, active-high
- in_valid  in  1  input group valid
- in_ready  out  1  pipeline can accept this cycle
- in_lane_en  in  LANES  per-lane enable; bit i qualifies lane i
- in_data  in  LANES*WIDTH  lane i at [i*WIDTH +: WIDTH]
- out_valid  out  1  output group valid (stage DEPTH-1)
- out_ready  in  1  downstream accepts this cycle
- out_lane_en  out  LANES  lane mask travelling with the data
- out_data  out  LANES*WIDTH  lane i at [i*WIDTH +: WIDTH]
- count  out  CW  number of occupied stages, 0..DEPTH

## Operation
- Each stage k (0..DEPTH-1) holds v[k], m[k] (LANES bits) and d[k] (LANES*WIDTH bits). Stage 0 is the input side; stage DEPTH-1 drives out_valid/out_lane_en/out_data directly.
- Advance enables, all combinational:
  - adv[DEPTH-1] = !v[DEPTH-1] | out_ready
  - adv[k] = !v[k] | adv[k+1]
  - in_ready = adv[0] & !flush
- Bubbles collapse: an empty stage always loads from its predecessor.
- When adv[k] is set, stage k loads from its source: stage k-1, or the input for k=0. The source for k=0 is in_valid & in_ready, in_lane_en, in_data.
- Masking at capture: lane i of d[0] is loaded with in_data lane i if in_lane_en[i]=1, else zero. m[0] is loaded with in_lane_en.
- Invalid load: a stage loading v=0 also loads m=0 and d=0. out_data and out_lane_en are therefore all-zero whenever out_valid=0.
- Transfer occurs on the input when in_valid & in_ready, and on the output when out_valid & out_ready. A group with in_lane_en=0 but in_valid=1 is still a valid group and propagates with zero data.
- count = number of stages with v=1, updated with the stage registers.
- flush=1 (with reset=1): all v, m and d are cleared to 0 at the edge. Any input group offered that cycle is dropped, since in_ready=0. The output group present that cycle is considered consumed only if out_ready=1; it is cleared either way.
- reset=0: same clearing as flush and takes priority over flush. in_ready is not gated by reset, but nothing captured while reset=0 survives the edge.
- Ordering is strict FIFO; no group is duplicated or reordered.

## Timing
- Reset values: out_valid=0, out_lane_en=0, out_data=0, count=0. in_ready=1 after reset, with flush=0.
- Latency, empty pipe with out_ready=1: a group accepted at edge t shows out_valid=1 after edge t+DEPTH-1 (DEPTH cycles from in_valid assertion to out_valid).
- Throughput: one group per cycle while out_ready=1.
- Storage: with out_ready=0, the pipe accepts exactly DEPTH groups, then in_ready=0 and count=DEPTH.
- Full pipe with out_ready=1: in_ready=1 in the same cycle. Simultaneous accept and emit leaves count unchanged.
- in_ready has a combinational path from out_ready and flush. All other outputs are registered.
- Input signals are sampled only at the clk edge. in_data and in_lane_en are ignored when in_valid=0.

## Test plan
- Reset: hold reset=0 for 2 cycles with in_valid=1 and in_data=16'hFFFF. Required: out_valid=0, out_data=0 and count=0 after release, and in_ready=1.
- Streaming, LANES=2 / WIDTH=8 / DEPTH=2, out_ready=1: send 16'h0102, 16'h0304, 16'h0506 on consecutive cycles with in_lane_en=2'b11. Required: outputs appear in order, the first 2 cycles after acceptance, one per cycle.
- Masking: send in_data=16'hA5C3 with in_lane_en=2'b01. Required: out_data=16'h00C3 and out_lane_en=2'b01.
- Back-pressure: with out_ready=0, offer 3 groups. Required: 2 accepted, count=2, in_ready=0, and the 3rd held by the source. Then raise out_ready. Required: all 3 groups emerge in order with no loss.
- Flush: fill 2 groups, then pulse flush=1 with in_valid=1. Required: next cycle count=0, out_valid=0 and out_data=0, the offered group is dropped, and in_ready=1 again.
- Random stall: drive random in_valid/out_ready for 10k cycles. A scoreboard must see an exact FIFO match, and count must always equal accepted minus emitted.
